// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified memory port.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if;
  // Requester side
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [2:0]  funct3_0;
  logic [2:0]  funct3_1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata;

  // Memory side
  logic [31:0] mem_addr;
  logic [2:0]  mem_funct3;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, funct3_0, funct3_1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_addr, mem_funct3, mem_wren, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, funct3_0, funct3_1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_addr, mem_funct3, mem_wren, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single unified memory port: one access issued per cycle,
// loads tracked through a READ_LATENCY-deep pipe so returned data is steered to its issuer.
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ROUND_ROBIN  = 1
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_port_arbiter_if.slave bus_io
);

  logic                    last_winner_q, last_winner_d;
  logic                    gnt0, gnt1, issue;
  logic                    mem_wren;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    push_vld;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_port_q, pipe_port_d;

  // Arbitration: on contention round-robin favours the port that did not win last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset_i) begin
      unique case ({bus_io.req1, bus_io.req0})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (ROUND_ROBIN != 0 && !last_winner_q) begin
            gnt1 = 1'b1;
          end else begin
            gnt0 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign issue = gnt0 | gnt1;

  always_comb begin
    last_winner_d = last_winner_q;
    if (gnt1) begin
      last_winner_d = 1'b1;
    end else if (gnt0) begin
      last_winner_d = 1'b0;
    end
  end

  // Issue mux; idle cycles keep presenting the last issued payload.
  always_comb begin
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    mem_wren = 1'b0;
    if (reset_i) begin
      addr_d   = '0;
      funct3_d = 3'b010;
      wdata_d  = '0;
    end else if (gnt1) begin
      addr_d   = bus_io.addr1;
      funct3_d = bus_io.funct3_1;
      wdata_d  = bus_io.wdata1;
      mem_wren = bus_io.we1;
    end else if (gnt0) begin
      addr_d   = bus_io.addr0;
      funct3_d = bus_io.funct3_0;
      wdata_d  = bus_io.wdata0;
      mem_wren = bus_io.we0;
    end
  end

  assign push_vld = issue & ~mem_wren;

  // Read-tracking shift pipe: entry 0 is the newest, the top entry lines up with mem_rdata.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_port_d    = pipe_port_q;
    pipe_vld_d[0]  = push_vld;
    pipe_port_d[0] = gnt1;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_port_d[i] = pipe_port_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_winner_q <= 1'b1;
      addr_q        <= '0;
      funct3_q      <= 3'b010;
      wdata_q       <= '0;
      pipe_vld_q    <= '0;
      pipe_port_q   <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_port_q   <= pipe_port_d;
    end
  end

  assign bus_io.gnt0       = gnt0;
  assign bus_io.gnt1       = gnt1;
  assign bus_io.mem_addr   = addr_d;
  assign bus_io.mem_funct3 = funct3_d;
  assign bus_io.mem_wdata  = wdata_d;
  assign bus_io.mem_wren   = mem_wren;
  assign bus_io.rdata      = bus_io.mem_rdata;
  assign bus_io.rvalid0    = ~reset_i & pipe_vld_q[READ_LATENCY-1] & ~pipe_port_q[READ_LATENCY-1];
  assign bus_io.rvalid1    = ~reset_i & pipe_vld_q[READ_LATENCY-1] &  pipe_port_q[READ_LATENCY-1];

  a_gnt_exclusive : assert property (@(posedge clk_i) !(gnt0 && gnt1));
  a_no_wren_in_reset : assert property (@(posedge clk_i) reset_i |-> !mem_wren);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: a round-robin/latency-1 and a fixed-priority/latency-3 arbiter share one stimulus
// stream; each has its own memory and is scored against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  f3_0, f3_1;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  assign ifa.req0 = req0;       assign ifb.req0 = req0;
  assign ifa.req1 = req1;       assign ifb.req1 = req1;
  assign ifa.we0 = we0;         assign ifb.we0 = we0;
  assign ifa.we1 = we1;         assign ifb.we1 = we1;
  assign ifa.addr0 = addr0;     assign ifb.addr0 = addr0;
  assign ifa.addr1 = addr1;     assign ifb.addr1 = addr1;
  assign ifa.funct3_0 = f3_0;   assign ifb.funct3_0 = f3_0;
  assign ifa.funct3_1 = f3_1;   assign ifb.funct3_1 = f3_1;
  assign ifa.wdata0 = wdata0;   assign ifb.wdata0 = wdata0;
  assign ifa.wdata1 = wdata1;   assign ifb.wdata1 = wdata1;

  mem_port_arbiter #(.READ_LATENCY(LAT_A), .ROUND_ROBIN(1)) u_dut_rr (
    .clk_i(clk), .reset_i(rst), .bus_io(ifa.slave)
  );
  mem_port_arbiter #(.READ_LATENCY(LAT_B), .ROUND_ROBIN(0)) u_dut_fp (
    .clk_i(clk), .reset_i(rst), .bus_io(ifb.slave)
  );

  logic        o_gnt0[2], o_gnt1[2], o_wren[2], o_rv0[2], o_rv1[2];
  logic [31:0] o_addr[2], o_wdata[2], o_rdata[2];
  logic [2:0]  o_f3[2];
  assign o_gnt0[0] = ifa.gnt0;      assign o_gnt0[1] = ifb.gnt0;
  assign o_gnt1[0] = ifa.gnt1;      assign o_gnt1[1] = ifb.gnt1;
  assign o_wren[0] = ifa.mem_wren;  assign o_wren[1] = ifb.mem_wren;
  assign o_rv0[0] = ifa.rvalid0;    assign o_rv0[1] = ifb.rvalid0;
  assign o_rv1[0] = ifa.rvalid1;    assign o_rv1[1] = ifb.rvalid1;
  assign o_addr[0] = ifa.mem_addr;  assign o_addr[1] = ifb.mem_addr;
  assign o_wdata[0] = ifa.mem_wdata; assign o_wdata[1] = ifb.mem_wdata;
  assign o_rdata[0] = ifa.rdata;    assign o_rdata[1] = ifb.rdata;
  assign o_f3[0] = ifa.mem_funct3;  assign o_f3[1] = ifb.mem_funct3;

  // ---------------- memory devices (one per DUT) ----------------
  logic [31:0] dev_mem [logic [32:0]];
  logic [31:0] s_addr[2], s_wdata[2];
  logic        s_wren[2] = '{1'b0, 1'b0};
  logic [31:0] rpa;
  logic [31:0] rpb[3];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] dev_rd(input logic k, input logic [31:0] a);
    if (dev_mem.exists({k, a})) return dev_mem[{k, a}];
    return init_word(a);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_addr[k]  = o_addr[k];
      s_wdata[k] = o_wdata[k];
      s_wren[k]  = (o_wren[k] === 1'b1);
    end
  end

  always @(posedge clk) begin
    rpa    <= dev_rd(1'b0, s_addr[0]);
    rpb[0] <= dev_rd(1'b1, s_addr[1]);
    rpb[1] <= rpb[0];
    rpb[2] <= rpb[1];
    if (s_wren[0]) dev_mem[{1'b0, s_addr[0]}] = s_wdata[0];
    if (s_wren[1]) dev_mem[{1'b1, s_addr[1]}] = s_wdata[1];
  end
  assign ifa.mem_rdata = rpa;
  assign ifb.mem_rdata = rpb[2];

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int          k;
    int          due;
    int          port;
    logic [31:0] data;
  } pend_t;

  pend_t       pq[$];
  int          cyc = 0;
  int          m_lw[2] = '{1, 1};
  logic [31:0] m_addr[2] = '{32'h0, 32'h0};
  logic [31:0] m_wd[2] = '{32'h0, 32'h0};
  logic [2:0]  m_f3[2] = '{3'b010, 3'b010};
  logic [31:0] m_mem [logic [32:0]];
  int          wait_c[2] = '{0, 0};

  function automatic logic [31:0] mdl_rd(input logic k, input logic [31:0] a);
    if (m_mem.exists({k, a})) return m_mem[{k, a}];
    return init_word(a);
  endfunction

  task automatic model_cycle();
    logic        eg0, eg1, ewr, erv0, erv1, rq, gt;
    logic [31:0] ea, ed, erd;
    logic [2:0]  ef;
    int          lat;
    pend_t       keep[$];
    string       tag;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? LAT_A : LAT_B;
      tag = $sformatf("k%0d cyc%0d", k, cyc);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!rst) begin
        if (req0 && req1) begin
          if (k == 0 && m_lw[k] == 0) eg1 = 1'b1;
          else eg0 = 1'b1;
        end else begin
          eg0 = req0;
          eg1 = req1;
        end
      end
      ewr = 1'b0;
      if (rst) begin
        ea = 32'h0; ef = 3'b010; ed = 32'h0;
      end else if (eg1) begin
        ea = addr1; ef = f3_1; ed = wdata1; ewr = we1;
      end else if (eg0) begin
        ea = addr0; ef = f3_0; ed = wdata0; ewr = we0;
      end else begin
        ea = m_addr[k]; ef = m_f3[k]; ed = m_wd[k];
      end
      erv0 = 1'b0;
      erv1 = 1'b0;
      erd  = 32'h0;
      if (!rst) begin
        foreach (pq[i]) begin
          if (pq[i].k == k && pq[i].due == cyc) begin
            if (pq[i].port == 1) erv1 = 1'b1;
            else erv0 = 1'b1;
            erd = pq[i].data;
          end
        end
      end
      chk({tag, " gnt0"}, 32'(o_gnt0[k]), 32'(eg0));
      chk({tag, " gnt1"}, 32'(o_gnt1[k]), 32'(eg1));
      chk({tag, " mem_wren"}, 32'(o_wren[k]), 32'(ewr));
      chk({tag, " mem_addr"}, o_addr[k], ea);
      chk({tag, " mem_funct3"}, 32'(o_f3[k]), 32'(ef));
      chk({tag, " mem_wdata"}, o_wdata[k], ed);
      chk({tag, " rvalid0"}, 32'(o_rv0[k]), 32'(erv0));
      chk({tag, " rvalid1"}, 32'(o_rv1[k]), 32'(erv1));
      if (erv0 || erv1) chk({tag, " rdata"}, o_rdata[k], erd);

      keep = {};
      foreach (pq[i]) if (!(pq[i].k == k && (rst || pq[i].due <= cyc))) keep.push_back(pq[i]);
      pq = keep;
      if (rst) begin
        m_lw[k] = 1; m_addr[k] = 32'h0; m_f3[k] = 3'b010; m_wd[k] = 32'h0;
      end else if (eg0 || eg1) begin
        m_lw[k] = eg1 ? 1 : 0;
        m_addr[k] = ea; m_f3[k] = ef; m_wd[k] = ed;
        if (ewr) m_mem[{k[0], ea}] = ed;
        else pq.push_back('{k, cyc + lat, eg1 ? 1 : 0, mdl_rd(k[0], ea)});
      end
    end
    // Round-robin fairness: a held request waits at most one cycle.
    for (int p = 0; p < 2; p++) begin
      rq = p ? req1 : req0;
      gt = p ? o_gnt1[0] : o_gnt0[0];
      if (rst || !rq) begin
        wait_c[p] = 0;
      end else if (gt === 1'b1) begin
        chk($sformatf("cyc%0d starve p%0d", cyc, p), 32'(wait_c[p] <= 1), 32'd1);
        wait_c[p] = 0;
      end else begin
        wait_c[p]++;
      end
    end
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        rst, r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  ga, gb;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic r0, input logic r1, input logic w0,
                              input logic w1, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [1:0] ga, input logic [1:0] gb);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = 32'h0; v.d1 = d1; v.ga = ga; v.gb = gb;
    return v;
  endfunction

  task automatic drive(input logic rs, input logic r0, input logic r1, input logic w0,
                       input logic w1, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [2:0] fa, input logic [2:0] fb);
    @(posedge clk);
    #1;
    rst = rs; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; f3_0 = fa; f3_1 = fb;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);
  endtask

  vec_t        tbl[$];
  logic        rv0_log[8], rv1_log[8];
  logic [31:0] rd_log[8];
  logic        pend[2];
  logic        pwe[2];
  logic [31:0] pa[2], pd[2];
  logic [2:0]  pf[2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; f3_0 = 3'b010; f3_1 = 3'b010;

    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h1000, 32'h1004, 32'h0, 2'b00, 2'b00));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 32'h1000, 32'h1004, 32'h0,
                       (i % 2 == 0) ? 2'b01 : 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0, 32'h2004, 32'hDEADBEEF, 2'b10, 2'b10));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h2004, 32'h0, 32'h0, 2'b01, 2'b01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h3000, 32'h0, 32'h0, 2'b01, 2'b01));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h3000, 32'h3000, 32'h12345678, 2'b10, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h3000, 32'h0, 32'h0, 2'b01, 2'b01));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // Load granted then reset next cycle: that load must never return.
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h1000, 32'h0, 32'h0, 2'b01, 2'b01));
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h1000, 32'h1004, 32'h0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h1000, 32'h1004, 32'h0, 2'b01, 2'b01));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
            tbl[i].d0, tbl[i].d1, 3'b010, 3'b010);
      chk($sformatf("tbl%0d gnt rr", i), 32'({o_gnt1[0], o_gnt0[0]}), 32'(tbl[i].ga));
      chk($sformatf("tbl%0d gnt fp", i), 32'({o_gnt1[1], o_gnt0[1]}), 32'(tbl[i].gb));
    end

    // Single load on the latency-1 arbiter: grant now, data next cycle on port 0 only.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);
    chk("t1 gnt0", 32'(o_gnt0[0]), 32'd1);
    chk("t1 wren", 32'(o_wren[0]), 32'd0);
    idle();
    chk("t1 rvalid0", 32'(o_rv0[0]), 32'd1);
    chk("t1 rvalid1", 32'(o_rv1[0]), 32'd0);
    chk("t1 rdata", o_rdata[0], init_word(32'h1000));
    for (int i = 0; i < 3; i++) idle();

    // Latency-3 arbiter: loads p0,p1,p0 back to back return on cycles 3,4,5.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);
    rv0_log[0] = o_rv0[1]; rv1_log[0] = o_rv1[1]; rd_log[0] = o_rdata[1];
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0, 3'b010, 3'b010);
    rv0_log[1] = o_rv0[1]; rv1_log[1] = o_rv1[1]; rd_log[1] = o_rdata[1];
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);
    rv0_log[2] = o_rv0[1]; rv1_log[2] = o_rv1[1]; rd_log[2] = o_rdata[1];
    for (int i = 3; i < 8; i++) begin
      idle();
      rv0_log[i] = o_rv0[1]; rv1_log[i] = o_rv1[1]; rd_log[i] = o_rdata[1];
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4 c%0d rvalid0", i), 32'(rv0_log[i]), 32'(i == 3 || i == 5));
      chk($sformatf("t4 c%0d rvalid1", i), 32'(rv1_log[i]), 32'(i == 4));
    end
    chk("t4 rdata c3", rd_log[3], init_word(32'h40));
    chk("t4 rdata c4", rd_log[4], init_word(32'h44));
    chk("t4 rdata c5", rd_log[5], init_word(32'h48));

    // Randomised traffic: requests held until granted by the round-robin arbiter.
    pend = '{1'b0, 1'b0};
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 55) begin
          pend[p] = 1'b1;
          pwe[p]  = ($urandom_range(0, 99) < 35);
          pa[p]   = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          pd[p]   = $urandom;
          pf[p]   = 3'($urandom_range(0, 7));
        end else if (pend[p] && $urandom_range(0, 99) < 5) begin
          pend[p] = 1'b0;
        end
      end
      drive($urandom_range(0, 79) == 0, pend[0], pend[1], pwe[0], pwe[1], pa[0], pa[1],
            pd[0], pd[1], pf[0], pf[1]);
      if (o_gnt0[0] === 1'b1) pend[0] = 1'b0;
      if (o_gnt1[0] === 1'b1) pend[1] = 1'b0;
    end
    for (int i = 0; i < 5; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
